// File: rtl/commit_unit_pkg.sv
// Shared core types for the rename/commit slice: physical register handles,
// renamed instructions, branch resolutions and the in-order tracking entry.
package commit_unit_pkg;

    localparam int PHYS_IDX_W    = 6;
    localparam int ROB_DEPTH_DEF = 16;

    typedef struct packed {
        logic                  valid;
        logic [PHYS_IDX_W-1:0] idx;
    } p_reg_t;

    typedef struct packed {
        logic   valid;
        p_reg_t rd;
    } rinstr_t;

    typedef struct packed {
        logic valid;
        logic hit;
    } br_result_t;

    typedef struct packed {
        logic   valid;
        logic   done;
        logic   is_branch;
        p_reg_t rd;
    } rob_entry_t;

    // p0 is hardwired, so only a valid non-zero destination counts as renamed
    function automatic logic has_dest(input p_reg_t r);
        return r.valid && (r.idx != '0);
    endfunction

endpackage

// File: rtl/commit_unit.sv
// In-order commit tracker: allocates renamed instructions, collects writebacks
// and branch outcomes, and retires one entry per cycle back to rename.
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int P_IDX_W   = PHYS_IDX_W
) (
    input  logic       clk,
    input  logic       rst_ni,
    input  rinstr_t    rinstr_i,
    input  logic       is_branch_i,
    input  p_reg_t     wb_i,
    input  br_result_t br_result_i,
    output p_reg_t     p_commit_o,
    output logic       rob_full_o
);

    localparam int PTR_W = $clog2(ROB_DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   count_t;

    localparam ptr_t   PTR_ONE = ptr_t'(1);
    localparam count_t CNT_ONE = count_t'(1);

    rob_entry_t rob_q [ROB_DEPTH];
    rob_entry_t rob_d [ROB_DEPTH];

    ptr_t   head_q, head_d;
    ptr_t   tail_q, tail_d;
    ptr_t   br_ptr_q, br_ptr_d;
    count_t count_q, count_d;
    logic   br_active_q, br_active_d;
    p_reg_t commit_q, commit_d;

    logic             retire;
    logic             resolve;
    logic             flush;
    logic             alloc;
    logic             new_branch;
    ptr_t             br_off;
    ptr_t             off;
    logic [P_IDX_W-1:0] wb_idx;

    assign wb_idx     = wb_i.idx;
    assign rob_full_o = (count_q == count_t'(ROB_DEPTH));
    assign p_commit_o = commit_q;

    always_comb begin
        rob_d       = rob_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        br_active_d = br_active_q;
        br_ptr_d    = br_ptr_q;
        commit_d    = '0;
        off         = '0;

        br_off     = br_ptr_q - head_q;
        retire     = (count_q != '0) && rob_q[head_q].done;
        resolve    = br_result_i.valid && br_active_q;
        flush      = resolve && !br_result_i.hit;
        alloc      = rinstr_i.valid && !rob_full_o && !flush;
        new_branch = is_branch_i && !br_active_q;

        for (int i = 0; i < ROB_DEPTH; i++) begin
            if (wb_i.valid && rob_q[i].valid && !rob_q[i].done &&
                rob_q[i].rd.valid && (rob_q[i].rd.idx == wb_idx)) begin
                rob_d[i].done = 1'b1;
            end
        end

        if (resolve) begin
            rob_d[br_ptr_q].done = 1'b1;
            br_active_d          = 1'b0;
        end

        // Everything allocated after the mispredicted branch is younger by offset from head
        if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                off = ptr_t'(i) - head_q;
                if (off > br_off) begin
                    rob_d[i] = '0;
                end
            end
            tail_d  = br_ptr_q + PTR_ONE;
            count_d = {1'b0, br_off} + CNT_ONE;
        end

        // Retire sees registered done only, so a same-cycle writeback retires a cycle later
        if (retire) begin
            rob_d[head_q] = '0;
            head_d        = head_q + PTR_ONE;
            count_d       = count_d - CNT_ONE;
            if (has_dest(rob_q[head_q].rd)) begin
                commit_d = rob_q[head_q].rd;
            end
        end

        if (alloc) begin
            rob_d[tail_q].valid     = 1'b1;
            rob_d[tail_q].rd        = rinstr_i.rd;
            rob_d[tail_q].is_branch = new_branch;
            rob_d[tail_q].done      = !has_dest(rinstr_i.rd) && !new_branch;
            tail_d                  = tail_q + PTR_ONE;
            count_d                 = count_d + CNT_ONE;
            if (new_branch) begin
                br_active_d = 1'b1;
                br_ptr_d    = tail_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            br_ptr_q    <= '0;
            count_q     <= '0;
            br_active_q <= 1'b0;
            commit_q    <= '0;
        end else begin
            rob_q       <= rob_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            br_ptr_q    <= br_ptr_d;
            count_q     <= count_d;
            br_active_q <= br_active_d;
            commit_q    <= commit_d;
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: drives rename/writeback/branch traffic and
// checks commit order, full flag and reset behaviour against hand-derived values.
module tb_commit_unit;
    import commit_unit_pkg::*;

    logic       clk;
    logic       rst_ni;
    rinstr_t    rinstr;
    logic       is_branch;
    p_reg_t     wb;
    br_result_t br_result;
    p_reg_t     p_commit;
    logic       rob_full;

    int tests_run = 0;
    int tests_failed = 0;
    int commit_log[$];
    int exp_log[$];

    commit_unit #(.ROB_DEPTH(16), .P_IDX_W(6)) dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .rinstr_i    (rinstr),
        .is_branch_i (is_branch),
        .wb_i        (wb),
        .br_result_i (br_result),
        .p_commit_o  (p_commit),
        .rob_full_o  (rob_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every commit pulse lasts one cycle, so one sample per falling edge logs each once
    always @(negedge clk) begin
        if (rst_ni && p_commit.valid) commit_log.push_back(int'(p_commit.idx));
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic a_v, input logic rd_v, input logic [5:0] rd_idx,
                                 input logic br, input logic w_v, input logic [5:0] w_idx,
                                 input logic b_v, input logic b_hit);
        rinstr.valid    = a_v;
        rinstr.rd.valid = rd_v;
        rinstr.rd.idx   = rd_idx;
        is_branch       = br;
        wb.valid        = w_v;
        wb.idx          = w_idx;
        br_result.valid = b_v;
        br_result.hit   = b_hit;
        @(posedge clk);
        #1;
        rinstr    = '0;
        is_branch = 1'b0;
        wb        = '0;
        br_result = '0;
    endtask

    task automatic allocReg(input int idx);
        applyStimulus(1'b1, 1'b1, 6'(idx), 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic writeBack(input int idx);
        applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'(idx), 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic checkCommits(input string tag);
        checkOutput($sformatf("%s_count", tag), 32'(commit_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < commit_log.size(); i++)
            checkOutput($sformatf("%s_idx%0d", tag, i), 32'(commit_log[i]), 32'(exp_log[i]));
        commit_log.delete();
        exp_log.delete();
    endtask

    task automatic pulseReset();
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("rst_full", 32'(rob_full), 32'd0);
        checkOutput("rst_commit", 32'(p_commit), 32'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni    = 1'b0;
        rinstr    = '0;
        is_branch = 1'b0;
        wb        = '0;
        br_result = '0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        checkOutput("reset_full", 32'(rob_full), 32'd0);
        checkOutput("reset_commit", 32'(p_commit), 32'd0);

        // Single entry: commit appears the cycle after the retire cycle
        allocReg(40);
        writeBack(40);
        checkOutput("single_pre", 32'(p_commit.valid), 32'd0);
        idle(1);
        checkOutput("single_valid", 32'(p_commit.valid), 32'd1);
        checkOutput("single_idx", 32'(p_commit.idx), 32'd40);
        idle(1);
        checkOutput("single_post", 32'(p_commit.valid), 32'd0);
        commit_log.delete();

        // Out-of-order writeback still commits in program order, back to back
        allocReg(40); allocReg(41); allocReg(42);
        writeBack(42); writeBack(41); writeBack(40);
        checkOutput("order_pre", 32'(p_commit.valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            checkOutput($sformatf("order_c%0d", k), 32'(p_commit), {25'd0, 1'b1, 6'(40 + k)});
        end
        idle(1);
        checkOutput("order_post", 32'(p_commit.valid), 32'd0);
        commit_log.delete();

        // Fill to capacity, overflow is dropped, head writeback frees a slot
        for (int k = 1; k <= 15; k++) allocReg(k);
        checkOutput("fill15_full", 32'(rob_full), 32'd0);
        allocReg(16);
        checkOutput("fill16_full", 32'(rob_full), 32'd1);
        allocReg(50);
        checkOutput("overflow_full", 32'(rob_full), 32'd1);
        writeBack(1);
        checkOutput("wbhead_full", 32'(rob_full), 32'd1);
        idle(1);
        checkOutput("retire_full", 32'(rob_full), 32'd0);
        for (int k = 2; k <= 16; k++) writeBack(k);
        idle(20);
        writeBack(50);
        idle(3);
        for (int k = 1; k <= 16; k++) exp_log.push_back(k);
        checkCommits("full");
        checkOutput("drain_full", 32'(rob_full), 32'd0);

        // Mispredict flushes younger entries and a same-cycle allocation
        allocReg(33);
        applyStimulus(1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        allocReg(34);
        allocReg(35);
        applyStimulus(1'b1, 1'b1, 6'd36, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        writeBack(33); writeBack(34); writeBack(35); writeBack(36);
        idle(5);
        allocReg(20);
        writeBack(20);
        idle(4);
        exp_log.push_back(33);
        exp_log.push_back(20);
        checkCommits("flush");

        // Correctly predicted branch only retires once resolved
        applyStimulus(1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        allocReg(21);
        writeBack(21);
        idle(4);
        checkCommits("br_wait");
        applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
        idle(4);
        exp_log.push_back(21);
        checkCommits("br_hit");

        // Silent retires of x0 / no-dest entries across pointer wrap, with periodic real commits
        for (int k = 0; k < 40; k++) begin
            logic       w_v;
            logic [5:0] w_idx;
            w_v   = (k % 10 == 0) && (k != 0);
            w_idx = 6'(20 + k / 10 - 1);
            if (k % 10 == 9)
                applyStimulus(1'b1, 1'b1, 6'(20 + k / 10), 1'b0, w_v, w_idx, 1'b0, 1'b0);
            else if (k % 2 == 0)
                applyStimulus(1'b1, 1'b1, 6'd0, 1'b0, w_v, w_idx, 1'b0, 1'b0);
            else
                applyStimulus(1'b1, 1'b0, 6'd9, 1'b0, w_v, w_idx, 1'b0, 1'b0);
            if (k == 20) checkOutput("wrap_full", 32'(rob_full), 32'd0);
        end
        writeBack(23);
        idle(5);
        allocReg(7);
        writeBack(7);
        idle(4);
        for (int k = 20; k <= 23; k++) exp_log.push_back(k);
        exp_log.push_back(7);
        checkCommits("wrap");

        // Reset while full clears the full flag and the count
        for (int k = 1; k <= 16; k++) allocReg(k);
        checkOutput("prerst_full", 32'(rob_full), 32'd1);
        pulseReset();

        // Reset with five pending entries: nothing committed afterwards
        for (int k = 1; k <= 5; k++) allocReg(k);
        writeBack(1);
        pulseReset();
        for (int k = 1; k <= 5; k++) writeBack(k);
        idle(5);
        checkCommits("rst_pending");
        for (int k = 1; k <= 15; k++) allocReg(k);
        checkOutput("postrst_15", 32'(rob_full), 32'd0);
        allocReg(16);
        checkOutput("postrst_16", 32'(rob_full), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 Parameter ROB_DEPTH, default 16, number of in-order tracking entries (power of two).
REQ-002 Parameter P_IDX_W, default 6, physical register index width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 rinstr_i  input  rinstr_t  renamed instruction from rename; allocates an entry when .valid.
REQ-006 is_branch_i  input  1  qualifies rinstr_i as the single tracked branch.
REQ-007 wb_i  input  p_reg_t  execution writeback; .valid with .idx marks the producing entry done.
REQ-008 br_result_i  input  br_result_t  branch resolution; .valid, .hit=1 correct, .hit=0 mispredict.
REQ-009 p_commit_o  output  p_reg_t  retired destination physical register, feeds rename p_commit_i.
REQ-010 rob_full_o  output  1  no free entry; upstream stalls dispatch.

Function
REQ-011 Allocate at tail when rinstr_i.valid && !rob_full_o; tail+1, count+1, store rd.valid, rd.idx, is_branch_i.
REQ-012 rinstr_i.valid while rob_full_o: instruction dropped, no state change; holding it is upstream's job.
REQ-013 Allocated entry is done at allocation if it has no renamed destination (rd.valid=0 or rd.idx=0) and is not a branch.
REQ-014 wb_i.valid sets done on every valid, not-done entry whose rd.idx equals wb_i.idx.
REQ-015 A branch entry becomes done on br_result_i.valid while a branch is active.
REQ-016 Retire at most one entry per cycle: the head is retired when count!=0 and head entry done; head+1, count-1.
REQ-017 Retire of entry with rd.valid && rd.idx!=0 drives p_commit_o.valid=1, p_commit_o.idx=rd.idx the next cycle (registered).
REQ-018 Retire of entry without a renamed destination, or no retire, drives p_commit_o.valid=0 the next cycle; p0 is never committed.
REQ-019 Branch allocation sets br_active=1 and br_ptr=tail; is_branch_i while br_active is ignored as a branch (entry allocated as non-branch).
REQ-020 br_result_i.valid while !br_active: ignored.
REQ-021 br_result_i.valid && hit=1: br_active=0, branch entry done.
REQ-022 br_result_i.valid && hit=0: br_active=0, branch entry done, all entries younger than branch flushed: tail=br_ptr+1, count=(br_ptr+1)-head modulo depth, plus any same-cycle retire adjustment.
REQ-023 Allocation in the same cycle as a mispredict is discarded.
REQ-024 Allocation and retire in the same cycle: count unchanged, both pointers advance.
REQ-025 wb_i and retire of the same entry in one cycle: entry becomes done, retires no earlier than next cycle.
REQ-026 Pointers are log2(ROB_DEPTH) bits, wrap modulo ROB_DEPTH; count is log2(ROB_DEPTH)+1 bits.
REQ-027 rob_full_o = (count==ROB_DEPTH), combinational from registered state only.

Reset
REQ-028 Reset: head=0, tail=0, count=0, br_active=0, all entries invalid and not done.
REQ-029 Reset outputs: p_commit_o='0, rob_full_o=0; reset mid-operation discards all entries with no commit emitted.

Structure
REQ-030 rinstr_t, p_reg_t, br_result_t come from the shared core package; entry struct rob_entry_t and ROB_DEPTH default added there.
REQ-031 Single module, no sub-modules; entry storage is flop-based arrays.

Verification
REQ-032 Alloc rd p40, then wb_i idx=40 -> p_commit_o valid idx=40 exactly one cycle after the retire cycle.
REQ-033 Alloc p40,p41,p42; wb in order 42,41,40 -> commits 40,41,42 on consecutive cycles, in program order.
REQ-034 Alloc 16 entries none written back -> rob_full_o=1; 17th valid rinstr_i dropped; wb head -> full clears after retire.
REQ-035 Alloc p33, branch, p34, p35; br_result hit=0 -> p34,p35 flushed; wb 33 -> only 33 committed, no commit for branch.
REQ-036 Alloc rd x0 and rd-invalid entries -> retire silently, p_commit_o.valid stays 0; pointer wrap across index 15->0 verified over 40 entries.
REQ-037 Assert rst_ni low with 5 entries pending -> count=0, rob_full_o=0, p_commit_o.valid=0, no later commit of flushed entries.
